bv4_inv_pipe: RTL and testbench

BV4_INV_PIPE -- requirements
Module: bv4_inv_pipe

---
 rtl/aes128_package.sv | 22 ++
 rtl/bv2_mul.sv | 17 +
 rtl/bv4_inv_pipe.sv | 138 +++++++++++++
 tb/tb_bv4_inv_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_package.sv
// Shared GF(2^4)/GF(2^2) tower-field types and constants.
// Used by bv4_inv_pipe and bv2_mul.
package aes128_package;

  typedef logic [1:0] bv2_t;
  typedef logic [3:0] bv4_t;

  // GF(4) scaling constant N of the GF(16) tower polynomial
  localparam bv2_t BV4_INV_NU = 2'b10;

  typedef struct packed {
    bv2_t xh;
    bv2_t xl;
    bv2_t d;
  } bv4_inv_s1_t;

  // Squaring (and inversion) in GF(4) normal basis
  function automatic bv2_t bv2_swap(input bv2_t a);
    return {a[0], a[1]};
  endfunction

endpackage

// File: rtl/bv2_mul.sv
// GF(2^2) multiplier in normal basis {W^2, W}.
// Purely combinational.
module bv2_mul
  import aes128_package::*;
(
  input  bv2_t a_i,
  input  bv2_t b_i,
  output bv2_t y_o
);

  logic e;

  assign e   = (a_i[1] ^ a_i[0]) & (b_i[1] ^ b_i[0]);
  assign y_o = {(a_i[1] & b_i[1]) ^ e,
                (a_i[0] & b_i[0]) ^ e};

endmodule

// File: rtl/bv4_inv_pipe.sv
// Elastic pipelined GF(2^4) inverter (tower normal basis).
// Define BV4_INV_PIPE_OUT_REG_EN to add a registered output stage.
module bv4_inv_pipe
  import aes128_package::*;
(
  input  logic in_clock,
  input  logic in_reset,
  input  logic in_valid,
  output logic out_ready,
  input  bv4_t in_x,
  output logic out_valid,
  input  logic in_ready,
  output bv4_t out_y
);

  bv2_t        xh;
  bv2_t        xl;
  bv2_t        hl;
  bv2_t        sq_in;
  bv2_t        sq;
  bv2_t        d_c;
  bv2_t        dinv;
  bv2_t        yh;
  bv2_t        yl;
  bv4_t        y_c;
  bv4_inv_s1_t s1_d;
  bv4_inv_s1_t s1_q;
  logic        s1_full_d;
  logic        s1_full_q;
  logic        s1_take;
  logic        s1_move;
  logic        s1_load;

  assign xh    = in_x[3:2];
  assign xl    = in_x[1:0];
  assign sq_in = bv2_swap(xh ^ xl);

  bv2_mul u_mul_hl (
    .a_i (xh),
    .b_i (xl),
    .y_o (hl)
  );

  bv2_mul u_mul_sq (
    .a_i (sq_in),
    .b_i (BV4_INV_NU),
    .y_o (sq)
  );

  assign d_c  = hl ^ sq;
  assign dinv = bv2_swap(s1_q.d);

  bv2_mul u_mul_yh (
    .a_i (dinv),
    .b_i (s1_q.xl),
    .y_o (yh)
  );

  bv2_mul u_mul_yl (
    .a_i (dinv),
    .b_i (s1_q.xh),
    .y_o (yl)
  );

  assign y_c = {yh, yl};

  assign s1_move   = s1_full_q & s1_take;
  assign out_ready = ~in_reset &
                     (~s1_full_q | s1_move);
  assign s1_load   = in_valid & out_ready;

  // S1 next state: load new operand, or drain and zero
  always_comb begin
    s1_full_d = s1_full_q;
    s1_d      = s1_q;
    if (s1_load) begin
      s1_full_d = 1'b1;
      s1_d      = {xh, xl, d_c};
    end else if (s1_move) begin
      s1_full_d = 1'b0;
      s1_d      = '0;
    end
  end

  // S1 registers
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      s1_full_q <= 1'b0;
      s1_q      <= '0;
    end else begin
      s1_full_q <= s1_full_d;
      s1_q      <= s1_d;
    end
  end

`ifdef BV4_INV_PIPE_OUT_REG_EN
  logic s2_full_d;
  logic s2_full_q;
  bv4_t s2_y_d;
  bv4_t s2_y_q;
  logic s2_move;

  assign s2_move = s2_full_q & in_ready;
  assign s1_take = ~s2_full_q | s2_move;

  // S2 next state: capture result, or drain and zero
  always_comb begin
    s2_full_d = s2_full_q;
    s2_y_d    = s2_y_q;
    if (s1_move) begin
      s2_full_d = 1'b1;
      s2_y_d    = y_c;
    end else if (s2_move) begin
      s2_full_d = 1'b0;
      s2_y_d    = '0;
    end
  end

  // S2 registers drive the outputs directly
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      s2_full_q <= 1'b0;
      s2_y_q    <= '0;
    end else begin
      s2_full_q <= s2_full_d;
      s2_y_q    <= s2_y_d;
    end
  end

  assign out_valid = s2_full_q;
  assign out_y     = s2_y_q;
`else
  assign s1_take   = in_ready;
  assign out_valid = s1_full_q;
  assign out_y     = s1_full_q ? y_c : '0;
`endif

endmodule

// File: tb/tb_bv4_inv_pipe.sv
// Self-checking bench for bv4_inv_pipe.
// Follows the design's BV4_INV_PIPE_OUT_REG_EN build.
module tb_bv4_inv_pipe;

`ifdef BV4_INV_PIPE_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [1:0] NB = 2'b10;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv;
  logic       ir;
  logic       ordy;
  logic       ov;
  logic [3:0] x;
  logic [3:0] y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bv4_inv_pipe dut (
    .in_clock  (clk),
    .in_reset  (rst),
    .in_valid  (iv),
    .out_ready (ordy),
    .in_x      (x),
    .out_valid (ov),
    .in_ready  (ir),
    .out_y     (y)
  );

  function automatic int lg(input logic [1:0] a);
    case (a)
      2'b11:   return 0;
      2'b01:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] ex(input int k);
    case (k % 3)
      0:       return 2'b11;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] gf4_mul(
    input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    return ex(lg(a) + lg(b));
  endfunction

  function automatic logic [3:0] gf16_mul(
    input logic [3:0] a, input logic [3:0] b);
    logic [1:0] t;
    t = gf4_mul(NB, gf4_mul(a[3:2] ^ a[1:0],
                            b[3:2] ^ b[1:0]));
    return {gf4_mul(a[3:2], b[3:2]) ^ t,
            gf4_mul(a[1:0], b[1:0]) ^ t};
  endfunction

  function automatic logic [3:0] inv_ref(input logic [3:0] a);
    logic [3:0] r;
    r = 4'h0;
    for (int k = 1; k < 16; k++)
      if (gf16_mul(a, 4'(k)) == 4'hF) r = 4'(k);
    return r;
  endfunction

  task automatic test_reset;
    @(posedge clk); #1;
    rst = 1'b1; iv = 1'b1; x = 4'h5; ir = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (ov !== 1'b0) begin
        errors++; $display("FAIL reset_ov: got %b exp 0", ov);
      end
      checks++;
      if (y !== 4'h0) begin
        errors++; $display("FAIL reset_y: got %h exp 0", y);
      end
      checks++;
      if (ordy !== 1'b0) begin
        errors++; $display("FAIL reset_ready: got %b exp 0", ordy);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; iv = 1'b0; x = 4'h0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ordy !== 1'b1) begin
      errors++; $display("FAIL release_ready: got %b exp 1", ordy);
    end
    checks++;
    if (ov !== 1'b0) begin
      errors++; $display("FAIL release_ov: got %b exp 0", ov);
    end
  endtask

  task automatic test_identity;
    logic [3:0] vx[3];
    logic [3:0] vy[3];
    vx = '{4'h0, 4'hF, 4'h1};
    vy = '{4'h0, 4'hF, 4'hC};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      iv = 1'b1; x = vx[i]; ir = 1'b1;
      @(negedge clk);
      checks++;
      if (ordy !== 1'b1) begin
        errors++; $display("FAIL ident_ready x=%h: got %b exp 1", vx[i], ordy);
      end
      @(posedge clk); #1;
      iv = 1'b0; x = 4'h0;
      for (int k = 1; k <= LAT; k++) begin
        if (k > 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ov !== (k == LAT)) begin
          errors++;
          $display("FAIL ident_lat x=%h c%0d: got %b exp %b", vx[i], k, ov, k == LAT);
        end
      end
      checks++;
      if (y !== vy[i]) begin
        errors++; $display("FAIL ident_y x=%h: got %h exp %h", vx[i], y, vy[i]);
      end
    end
  endtask

  task automatic test_exhaustive;
    int         sent;
    int         got;
    int         first;
    int         last;
    int         cyc;
    logic [3:0] qx[$];
    logic [3:0] xi;
    sent = 0; got = 0; first = -1; last = -1; cyc = 0;
    @(posedge clk); #1;
    ir = 1'b1;
    while (got < 16 && cyc < 60) begin
      iv = (sent < 16);
      x  = sent[3:0];
      @(negedge clk);
      if (iv) begin
        checks++;
        if (ordy !== 1'b1) begin
          errors++; $display("FAIL exh_ready c%0d: got %b exp 1", cyc, ordy);
        end
      end
      if (iv && ordy) begin
        qx.push_back(x); sent++;
      end
      if (ov) begin
        checks++;
        if (qx.size() == 0) begin
          errors++; $display("FAIL exh_extra: got %h exp none", y);
        end else begin
          xi = qx.pop_front();
          checks++;
          if (y !== inv_ref(xi)) begin
            errors++; $display("FAIL exh_y x=%h: got %h exp %h", xi, y, inv_ref(xi));
          end
          if (xi != 4'h0) begin
            checks++;
            if (gf16_mul(y, xi) !== 4'hF) begin
              errors++; $display("FAIL exh_prod x=%h: got %h exp f", xi, gf16_mul(y, xi));
            end
          end
        end
        if (first < 0) first = cyc;
        last = cyc; got++;
      end else begin
        checks++;
        if (y !== 4'h0) begin
          errors++; $display("FAIL exh_idle_y: got %h exp 0", y);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv = 1'b0;
    checks++;
    if (got != 16) begin
      errors++; $display("FAIL exh_count: got %0d exp 16", got);
    end
    checks++;
    if (last - first != 15) begin
      errors++; $display("FAIL exh_rate: got span %0d exp 15", last - first);
    end
  endtask

  task automatic test_backpressure;
    int         sent;
    int         got;
    int         cyc;
    logic       seen_low;
    logic       stall_prev;
    logic [3:0] y_prev;
    logic [3:0] qx[$];
    logic [3:0] xi;
    sent = 0; got = 0; cyc = 0;
    seen_low = 1'b0; stall_prev = 1'b0; y_prev = 4'h0;
    @(posedge clk); #1;
    while (got < 8 && cyc < 60) begin
      iv = (sent < 8);
      x  = 4'(sent + 3);
      ir = !(cyc >= 2 && cyc < 7);
      @(negedge clk);
      if (stall_prev) begin
        checks++;
        if (!(ov === 1'b1 && y === y_prev)) begin
          errors++; $display("FAIL bp_hold: got %b/%h exp 1/%h", ov, y, y_prev);
        end
      end
      if (iv && !ordy) seen_low = 1'b1;
      if (iv && ordy) begin
        qx.push_back(x); sent++;
      end
      if (ov && ir) begin
        checks++;
        if (qx.size() == 0) begin
          errors++; $display("FAIL bp_extra: got %h exp none", y);
        end else begin
          xi = qx.pop_front();
          checks++;
          if (y !== inv_ref(xi)) begin
            errors++; $display("FAIL bp_y x=%h: got %h exp %h", xi, y, inv_ref(xi));
          end
        end
        got++;
      end
      stall_prev = ov && !ir;
      y_prev     = y;
      @(posedge clk); #1;
      cyc++;
    end
    iv = 1'b0; ir = 1'b1;
    checks++;
    if (seen_low !== 1'b1) begin
      errors++; $display("FAIL bp_ready_drop: got %b exp 1", seen_low);
    end
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL bp_count: got %0d exp 8", got);
    end
    checks++;
    if (qx.size() != 0) begin
      errors++; $display("FAIL bp_left: got %0d exp 0", qx.size());
    end
  endtask

  task automatic test_midreset;
    @(posedge clk); #1;
    ir = 1'b0; iv = 1'b1; x = 4'h2;
    @(negedge clk);
    checks++;
    if (ordy !== 1'b1) begin
      errors++; $display("FAIL mr_acc1: got %b exp 1", ordy);
    end
    @(posedge clk); #1;
    x = 4'h6;
    @(negedge clk);
    checks++;
    if (ordy !== (LAT == 2)) begin
      errors++; $display("FAIL mr_acc2: got %b exp %b", ordy, LAT == 2);
    end
    @(posedge clk); #1;
    rst = 1'b1; iv = 1'b1; x = 4'h9;
    @(negedge clk);
    checks++;
    if (ordy !== 1'b0) begin
      errors++; $display("FAIL mr_ready: got %b exp 0", ordy);
    end
    @(posedge clk); #1;
    rst = 1'b0; iv = 1'b0; x = 4'h0; ir = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (ov !== 1'b0 || y !== 4'h0) begin
        errors++; $display("FAIL mr_leak c%0d: got %b/%h exp 0/0", c, ov, y);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    int         cyc;
    logic       stall_prev;
    logic [3:0] y_prev;
    logic [3:0] qx[$];
    logic [3:0] xi;
    stall_prev = 1'b0; y_prev = 4'h0;
    @(posedge clk); #1;
    for (cyc = 0; cyc < 10020; cyc++) begin
      if (cyc < 10000) begin
        iv = ($urandom_range(0, 9) < 7);
        ir = ($urandom_range(0, 9) < 6);
        x  = 4'($urandom_range(0, 15));
      end else begin
        iv = 1'b0; ir = 1'b1;
      end
      @(negedge clk);
      if (stall_prev) begin
        checks++;
        if (!(ov === 1'b1 && y === y_prev)) begin
          errors++; $display("FAIL rnd_hold c%0d: got %b/%h exp 1/%h", cyc, ov, y, y_prev);
        end
      end
      if (!ov) begin
        checks++;
        if (y !== 4'h0) begin
          errors++; $display("FAIL rnd_idle_y c%0d: got %h exp 0", cyc, y);
        end
      end
      if (iv && ordy) qx.push_back(x);
      if (ov && ir) begin
        checks++;
        if (qx.size() == 0) begin
          errors++; $display("FAIL rnd_extra c%0d: got %h exp none", cyc, y);
        end else begin
          xi = qx.pop_front();
          if (y !== inv_ref(xi)) begin
            errors++; $display("FAIL rnd_y c%0d x=%h: got %h exp %h", cyc, xi, y, inv_ref(xi));
          end
        end
      end
      stall_prev = ov && !ir;
      y_prev     = y;
      @(posedge clk); #1;
    end
    checks++;
    if (qx.size() != 0) begin
      errors++; $display("FAIL rnd_left: got %0d exp 0", qx.size());
    end
  endtask

  initial begin
    rst = 1'b1; iv = 1'b0; ir = 1'b0; x = 4'h0;
    test_reset;
    test_identity;
    test_exhaustive;
    test_backpressure;
    test_midreset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
